// File: rtl/delay_and_sum_div_pkg.sv
// Shared widths, quotient bounds and FSM states for the signed 85/32 restoring divider.
package delay_and_sum_div_pkg;
  localparam int DIN0_W = 85;
  localparam int DIN1_W = 32;
  localparam int DOUT_W = 67;
  localparam int CNT_W  = 7;

  localparam logic [DOUT_W-1:0] QMAX = {1'b0, {(DOUT_W-1){1'b1}}};
  localparam logic [DOUT_W-1:0] QMIN = {1'b1, {(DOUT_W-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;
endpackage

// File: rtl/delay_and_sum_div_step.sv
// One restoring-division step on magnitudes: shift in the next dividend bit, trial-subtract.
module delay_and_sum_div_step
  import delay_and_sum_div_pkg::*;
#(
  parameter int W = DIN1_W
) (
  input  logic [W:0]   i_prem,
  input  logic [W-1:0] i_dvs,
  input  logic         i_bit,
  output logic [W:0]   o_prem,
  output logic         o_q
);
  logic [W+1:0] w_shift;
  logic [W+1:0] w_diff;

  assign w_shift = {i_prem, i_bit};
  assign w_diff  = w_shift - {2'b00, i_dvs};
  // A clear MSB means the trial subtraction did not go negative.
  assign o_q     = ~w_diff[W+1];
  assign o_prem  = o_q ? w_diff[W:0] : w_shift[W:0];
endmodule

// File: rtl/delay_and_sum_sdiv_85s_32s_67_seq.sv
// Iterative signed restoring divider (85s / 32s -> 67s quotient, 32s remainder), valid/ready both sides.
module delay_and_sum_sdiv_85s_32s_67_seq
  import delay_and_sum_div_pkg::*;
#(
  parameter int din0_WIDTH = DIN0_W,
  parameter int din1_WIDTH = DIN1_W,
  parameter int dout_WIDTH = DOUT_W
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  ce,
  input  logic [din0_WIDTH-1:0] din0,
  input  logic [din1_WIDTH-1:0] din1,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic [dout_WIDTH-1:0] dout,
  output logic [din1_WIDTH-1:0] rem,
  output logic                  dbz,
  output logic                  ovf,
  output logic                  out_valid,
  input  logic                  out_ready
);
  state_t r_state, w_next;

  logic [CNT_W-1:0]      r_cnt;
  logic [din0_WIDTH-1:0] r_dvd;   // dividend magnitude shifting out, quotient shifting in
  logic [din1_WIDTH-1:0] r_dvs;
  logic [din1_WIDTH:0]   r_prem;
  logic [din1_WIDTH-1:0] r_lo;
  logic                  r_sn0, r_sn1, r_zero;
  logic [dout_WIDTH-1:0] r_dout;
  logic [din1_WIDTH-1:0] r_rem;
  logic                  r_dbz, r_ovf, r_ov;

  logic [din1_WIDTH:0]   w_prem;
  logic                  w_q;
  logic                  w_last;
  logic                  w_neg;
  logic                  w_pos_ovf, w_neg_ovf;
  logic [dout_WIDTH-1:0] w_qlo, w_qneg;

  delay_and_sum_div_step #(.W(din1_WIDTH)) u_step (
    .i_prem (r_prem),
    .i_dvs  (r_dvs),
    .i_bit  (r_dvd[din0_WIDTH-1]),
    .o_prem (w_prem),
    .o_q    (w_q)
  );

  assign w_last = (r_cnt == CNT_W'(din0_WIDTH-1));
  assign w_neg  = r_sn0 ^ r_sn1;

  // Positive side tops out at 2^66-1; negative side may reach exactly 2^66.
  assign w_pos_ovf = |r_dvd[din0_WIDTH-1:dout_WIDTH-1];
  assign w_neg_ovf = (|r_dvd[din0_WIDTH-1:dout_WIDTH]) |
                     (r_dvd[dout_WIDTH-1] & (|r_dvd[dout_WIDTH-2:0]));
  assign w_qlo     = r_dvd[dout_WIDTH-1:0];
  assign w_qneg    = -w_qlo;

  always_ff @(posedge clk) begin
    if (reset) r_state <= IDLE;
    else if (ce) r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE: if (in_valid) w_next = CALC;
      CALC: if (w_last) w_next = FIX;
      FIX:  w_next = DONE;
      DONE: if (out_ready) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_cnt  <= '0;
      r_dvd  <= '0;
      r_dvs  <= '0;
      r_prem <= '0;
      r_lo   <= '0;
      r_sn0  <= 1'b0;
      r_sn1  <= 1'b0;
      r_zero <= 1'b0;
      r_dout <= '0;
      r_rem  <= '0;
      r_dbz  <= 1'b0;
      r_ovf  <= 1'b0;
      r_ov   <= 1'b0;
    end else if (ce) begin
      case (r_state)
        IDLE: if (in_valid) begin
          r_dvd  <= din0[din0_WIDTH-1] ? -din0 : din0;
          r_dvs  <= din1[din1_WIDTH-1] ? -din1 : din1;
          r_sn0  <= din0[din0_WIDTH-1];
          r_sn1  <= din1[din1_WIDTH-1];
          r_zero <= (din1 == '0);
          r_lo   <= din0[din1_WIDTH-1:0];
          r_prem <= '0;
          r_cnt  <= '0;
        end
        CALC: begin
          r_dvd  <= {r_dvd[din0_WIDTH-2:0], w_q};
          r_prem <= w_prem;
          r_cnt  <= r_cnt + 1'b1;
        end
        FIX: begin
          r_ov <= 1'b1;
          if (r_zero) begin
            r_dout <= r_sn0 ? QMIN : QMAX;
            r_rem  <= r_lo;
            r_dbz  <= 1'b1;
            r_ovf  <= 1'b0;
          end else begin
            r_dbz <= 1'b0;
            r_rem <= r_sn0 ? -r_prem[din1_WIDTH-1:0] : r_prem[din1_WIDTH-1:0];
            if (w_neg) begin
              r_dout <= w_neg_ovf ? QMIN : w_qneg;
              r_ovf  <= w_neg_ovf;
            end else begin
              r_dout <= w_pos_ovf ? QMAX : w_qlo;
              r_ovf  <= w_pos_ovf;
            end
          end
        end
        DONE: if (out_ready) r_ov <= 1'b0;
        default: ;
      endcase
    end
  end

  assign in_ready  = (r_state == IDLE);
  assign dout      = r_dout;
  assign rem       = r_rem;
  assign dbz       = r_dbz;
  assign ovf       = r_ovf;
  assign out_valid = r_ov;
endmodule

// File: tb/tb_delay_and_sum_sdiv_85s_32s_67_seq.sv
// Bench for the signed iterative divider: directed table, corner sequences, random vs arithmetic model.
module tb_delay_and_sum_sdiv_85s_32s_67_seq;
  logic        clk = 1'b0;
  logic        reset, ce, in_valid, out_ready;
  logic [84:0] din0;
  logic [31:0] din1;
  logic        in_ready, dbz, ovf, out_valid;
  logic [66:0] dout;
  logic [31:0] rem;

  int total = 0;
  int bad   = 0;

  localparam logic [66:0] QMAX = {1'b0, {66{1'b1}}};
  localparam logic [66:0] QMIN = {1'b1, {66{1'b0}}};
  localparam logic signed [95:0] QMAXW = (96'sd1 <<< 66) - 96'sd1;
  localparam logic signed [95:0] QMINW = -(96'sd1 <<< 66);

  typedef struct {
    logic [84:0] a;
    logic [31:0] b;
    logic [66:0] q;
    logic [31:0] r;
    logic        z;
    logic        o;
  } vec_t;

  vec_t tv[16];

  delay_and_sum_sdiv_85s_32s_67_seq dut (
    .clk(clk), .reset(reset), .ce(ce), .din0(din0), .din1(din1),
    .in_valid(in_valid), .in_ready(in_ready), .dout(dout), .rem(rem),
    .dbz(dbz), .ovf(ovf), .out_valid(out_valid), .out_ready(out_ready)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [127:0] got, input logic [127:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", nm, got, exp);
    end
  endtask

  // Truncating signed division in wide arithmetic, then clamp.
  task automatic model(input logic [84:0] a, input logic [31:0] b,
                       output logic [66:0] q, output logic [31:0] r,
                       output logic z, output logic o);
    logic signed [95:0] aw, bw, qw, rw;
    aw = {{11{a[84]}}, a};
    bw = {{64{b[31]}}, b};
    z  = (b == 32'd0);
    o  = 1'b0;
    if (z) begin
      q = a[84] ? QMIN : QMAX;
      r = a[31:0];
    end else begin
      qw = aw / bw;
      rw = aw % bw;
      if (qw > QMAXW)      begin q = QMAX; o = 1'b1; end
      else if (qw < QMINW) begin q = QMIN; o = 1'b1; end
      else                 q = qw[66:0];
      r = rw[31:0];
    end
  endtask

  task automatic run(input string nm, input logic [84:0] a, input logic [31:0] b,
                     input logic [66:0] eq, input logic [31:0] er, input logic ez, input logic eo,
                     input int ecyc, input bit tog, input bit pulse, input bit hold);
    int  cyc;
    int  w;
    bit  stable;
    w = 0;
    while (!in_ready && w < 200) begin @(posedge clk); #1; w++; end
    chk({nm, " rdy_in"}, in_ready, 1);
    ce = 1'b1; din0 = a; din1 = b; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    cyc = 0;
    while (!out_valid && cyc < 400) begin
      if (pulse && cyc == 10) begin in_valid = 1'b1; din0 = 85'd999; din1 = 32'd1; end
      else in_valid = 1'b0;
      ce = tog ? ~ce : 1'b1;
      @(posedge clk); #1;
      cyc++;
    end
    in_valid = 1'b0; ce = 1'b1;
    chk({nm, " latency"}, cyc, ecyc);
    chk({nm, " dout"}, dout, eq);
    chk({nm, " rem"}, rem, er);
    chk({nm, " dbz"}, dbz, ez);
    chk({nm, " ovf"}, ovf, eo);
    if (hold) begin
      stable = 1'b1;
      for (int i = 0; i < 10; i++) begin
        // one cycle offers out_ready with ce low: must still hold
        out_ready = (i == 5);
        ce = (i != 5);
        @(posedge clk); #1;
        if (!(out_valid === 1'b1 && dout === eq && rem === er && dbz === ez && ovf === eo))
          stable = 1'b0;
      end
      out_ready = 1'b0; ce = 1'b1;
      chk({nm, " hold"}, stable, 1);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk({nm, " ov_drop"}, out_valid, 0);
    chk({nm, " rdy_after"}, in_ready, 1);
  endtask

  initial begin
    logic [66:0] q;
    logic [31:0] r;
    logic        z, o;
    logic [95:0] t;
    logic [31:0] u;
    logic [84:0] a;
    logic [31:0] b;
    int          mode;

    tv[0]  = '{85'd100, 32'd7, 67'd14, 32'd2, 1'b0, 1'b0};
    tv[1]  = '{-85'd100, 32'd7, -67'd14, -32'd2, 1'b0, 1'b0};
    tv[2]  = '{85'd100, -32'd7, -67'd14, 32'd2, 1'b0, 1'b0};
    tv[3]  = '{-85'd100, -32'd7, 67'd14, -32'd2, 1'b0, 1'b0};
    tv[4]  = '{85'd1 << 80, 32'd1, QMAX, 32'd0, 1'b0, 1'b1};
    tv[5]  = '{85'd1 << 84, 32'hFFFF_FFFF, QMAX, 32'd0, 1'b0, 1'b1};
    tv[6]  = '{85'd5, 32'd0, QMAX, 32'd5, 1'b1, 1'b0};
    tv[7]  = '{-85'd5, 32'd0, QMIN, -32'd5, 1'b1, 1'b0};
    tv[8]  = '{(85'd1 << 66) - 85'd1, 32'd1, QMAX, 32'd0, 1'b0, 1'b0};
    tv[9]  = '{-(85'd1 << 66), 32'd1, QMIN, 32'd0, 1'b0, 1'b0};
    tv[10] = '{85'd1 << 66, 32'd1, QMAX, 32'd0, 1'b0, 1'b1};
    tv[11] = '{-(85'd1 << 66) - 85'd1, 32'd1, QMIN, 32'd0, 1'b0, 1'b1};
    tv[12] = '{85'd7, 32'd100, 67'd0, 32'd7, 1'b0, 1'b0};
    tv[13] = '{-85'd7, 32'd100, 67'd0, -32'd7, 1'b0, 1'b0};
    tv[14] = '{85'd1 << 40, 32'h8000_0000, -67'd512, 32'd0, 1'b0, 1'b0};
    tv[15] = '{(85'd1 << 40) + 85'd5, 32'h8000_0000, -67'd512, 32'd5, 1'b0, 1'b0};

    reset = 1'b1; ce = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    din0 = '0; din1 = '0;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0; ce = 1'b1;
    chk("rst in_ready", in_ready, 1);
    chk("rst out_valid", out_valid, 0);
    chk("rst dout", dout, 0);
    chk("rst rem", rem, 0);
    chk("rst dbz", dbz, 0);
    chk("rst ovf", ovf, 0);

    for (int i = 0; i < 16; i++)
      run($sformatf("vec%0d", i), tv[i].a, tv[i].b, tv[i].q, tv[i].r, tv[i].z, tv[i].o,
          86, 1'b0, 1'b0, 1'b0);

    // ce toggling, ignored in_valid pulse during CALC, and output hold
    run("ce_tog", 85'd100, 32'd7, 67'd14, 32'd2, 1'b0, 1'b0, 172, 1'b1, 1'b0, 1'b0);
    run("pulse", 85'd100, 32'd7, 67'd14, 32'd2, 1'b0, 1'b0, 86, 1'b0, 1'b1, 1'b0);
    run("hold", -85'd100, 32'd7, -67'd14, -32'd2, 1'b0, 1'b0, 86, 1'b0, 1'b0, 1'b1);

    // abort mid-CALC with reset, then a fresh operation
    ce = 1'b1; din0 = 85'd100; din1 = 32'd7; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (40) @(posedge clk);
    #1;
    chk("calc in_ready", in_ready, 0);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    chk("abort in_ready", in_ready, 1);
    chk("abort out_valid", out_valid, 0);
    chk("abort dout", dout, 0);
    run("after_abort", 85'd9, 32'd3, 67'd3, 32'd0, 1'b0, 1'b0, 86, 1'b0, 1'b0, 1'b0);

    for (int n = 0; n < 25; n++) begin
      mode = $urandom_range(0, 4);
      t = {$urandom(), $urandom(), $urandom()};
      u = $urandom();
      a = t[84:0];
      b = u;
      case (mode)
        1: a = {{65{t[19]}}, t[19:0]};
        2: b = 32'd0;
        3: b = {{24{u[7]}}, u[7:0]};
        4: a = {{30{t[54]}}, t[54:0]};
        default: ;
      endcase
      model(a, b, q, r, z, o);
      run($sformatf("rnd%0d", n), a, b, q, r, z, o, 86, 1'b0, 1'b0, 1'b0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
